nco_sweep_ctrl: RTL

Frequency-sweep scheduler for the lab NCO. Latches a sweep configuration (start, stop, increment, dwell) on a start pulse and drives the NCO `freq_step` tuning word: a linear staircase from start to stop, either once or as a continuous triangle. Sits between the switch/key front end and the NCO phase accumulator, replacing the static `SW`-derived tuning word.

---
 rtl/nco_pkg.sv | 15 +
 rtl/nco_dwell_timer.sv | 26 ++
 rtl/nco_sweep_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller and the NCO it drives.
package nco_pkg;

  localparam int FW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } sweep_state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_TRI    = 1'b1;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell counter: counts 0..limit, ticks on the terminal count and wraps; load restarts at 0.
module nco_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] limit,
  output logic          tick
);

  logic [DW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (load || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the NCO tuning word from f_start to f_stop,
// once or as a continuous triangle, holding each word for dwell+1 cycles.
module nco_sweep_ctrl #(
  parameter int FW = nco_pkg::FW,
  parameter int DW = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_inc,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] freq_step,
  output logic          freq_valid,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  import nco_pkg::*;

  sweep_state_e  state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] fstart_q, fstart_d;
  logic [FW-1:0] fstop_q, fstop_d;
  logic [FW-1:0] finc_q, finc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          mode_q, mode_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmr_load;
  logic          tick;

  // Carry out of the widened sum also saturates at the ceiling.
  function automatic logic [FW-1:0] step_up(input logic [FW-1:0] cur,
                                            input logic [FW-1:0] inc,
                                            input logic [FW-1:0] ceil);
    logic [FW:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, ceil}) return ceil;
    return sum[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] step_down(input logic [FW-1:0] cur,
                                              input logic [FW-1:0] inc,
                                              input logic [FW-1:0] floor);
    logic [FW:0] diff;
    diff = {1'b0, cur} - {1'b0, inc};
    if (diff[FW] || (diff[FW-1:0] < floor)) return floor;
    return diff[FW-1:0];
  endfunction

  nco_dwell_timer #(.DW(DW)) u_dwell (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .load  (tmr_load),
    .limit (dwell_q),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    finc_d   = finc_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      freq_d   = '0;
      vld_d    = 1'b1;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (f_start <= f_stop) begin
              fstart_d = f_start;
              fstop_d  = f_stop;
              finc_d   = f_inc;
              dwell_d  = dwell;
              mode_d   = mode;
              freq_d   = f_start;
              vld_d    = 1'b1;
              tmr_load = 1'b1;
              state_d  = ST_UP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_UP: begin
          if (tick) begin
            if (freq_q < fstop_q) begin
              freq_d = step_up(freq_q, finc_q, fstop_q);
              vld_d  = 1'b1;
            end else if (mode_q == MODE_TRI) begin
              state_d = ST_DOWN;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_DOWN: begin
          if (tick) begin
            if (freq_q > fstart_q) begin
              freq_d = step_down(freq_q, finc_q, fstart_q);
              vld_d  = 1'b1;
            end else begin
              state_d = ST_UP;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      freq_q   <= '0;
      fstart_q <= '0;
      fstop_q  <= '0;
      finc_q   <= '0;
      dwell_q  <= '0;
      mode_q   <= MODE_SINGLE;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      finc_q   <= finc_d;
      dwell_q  <= dwell_d;
      mode_q   <= mode_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign freq_step  = freq_q;
  assign freq_valid = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = err_q;

endmodule
